// File: rtl/aes_kat_checker.sv
// rtl/aes_kat_checker.sv - known-answer-test checker for a pipelined AES core
module aes_kat_checker #(
  parameter int DATA_W  = 128,
  parameter int LATENCY = 11,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              issue_valid,
  input  logic [DATA_W-1:0] issue_expected,
  input  logic              end_test,
  input  logic [DATA_W-1:0] dut_result,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              protocol_err,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  fail_cnt,
  output logic [CNT_W-1:0]  first_fail_idx,
  output logic [DATA_W-1:0] first_fail_data
);
  localparam int IW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t             state;
  state_t             state_d;
  logic               accept;
  logic               proto_hit;
  logic               compare;
  logic               drain_empty;
  logic [LATENCY-1:0] pipe_valid;
  logic [DATA_W-1:0]  pipe_exp [LATENCY];
  logic [CNT_W-1:0]   pipe_idx [LATENCY];
  logic [CNT_W-1:0]   issue_idx;
  logic [IW-1:0]      inflight;

  // The oldest stage lines up with the core output this cycle
  assign compare     = pipe_valid[LATENCY-1];
  // In DRAIN nothing is accepted, so inflight hits zero when the last one compares
  assign drain_empty = (inflight == IW'(compare));
  assign error       = (fail_cnt != '0) || protocol_err;

  // State register plus registered status flags derived from the next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_d;
      busy  <= (state_d == S_RUN) || (state_d == S_DRAIN);
      done  <= (state_d == S_DONE);
    end
  end

  // Next-state, issue acceptance and protocol-violation detection
  always_comb begin
    state_d   = state;
    accept    = 1'b0;
    proto_hit = 1'b0;
    case (state)
      S_IDLE: begin
        if (issue_valid) begin
          accept  = 1'b1;
          state_d = end_test ? S_DRAIN : S_RUN;
        end else if (end_test) begin
          state_d = S_DONE;
        end
      end
      S_RUN: begin
        accept = issue_valid;
        if (end_test) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        proto_hit = issue_valid;
        if (drain_empty) state_d = S_DONE;
      end
      S_DONE: begin
        proto_hit = issue_valid;
      end
      default: state_d = S_IDLE;
    endcase
    if (clear) begin
      state_d   = S_IDLE;
      accept    = 1'b0;
      proto_hit = 1'b0;
    end
  end

  // Valid bits of the delay line; cleared so no stale vector is ever compared
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_valid <= '0;
    end else if (clear) begin
      pipe_valid <= '0;
    end else begin
      pipe_valid[0] <= accept;
      for (int i = 1; i < LATENCY; i++) pipe_valid[i] <= pipe_valid[i-1];
    end
  end

  // Payload of the delay line; only meaningful where the matching valid is set
  always_ff @(posedge clk) begin
    pipe_exp[0] <= issue_expected;
    pipe_idx[0] <= issue_idx;
    for (int i = 1; i < LATENCY; i++) begin
      pipe_exp[i] <= pipe_exp[i-1];
      pipe_idx[i] <= pipe_idx[i-1];
    end
  end

  // Issue index (wrapping) and count of vectors still in the pipe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issue_idx <= '0;
      inflight  <= '0;
    end else if (clear) begin
      issue_idx <= '0;
      inflight  <= '0;
    end else begin
      if (accept) issue_idx <= issue_idx + 1'b1;
      if (accept && !compare)      inflight <= inflight + 1'b1;
      else if (!accept && compare) inflight <= inflight - 1'b1;
    end
  end

  // Result comparison, saturating statistics and first-failure capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pass_cnt        <= '0;
      fail_cnt        <= '0;
      first_fail_idx  <= '0;
      first_fail_data <= '0;
      protocol_err    <= 1'b0;
    end else if (clear) begin
      pass_cnt        <= '0;
      fail_cnt        <= '0;
      first_fail_idx  <= '0;
      first_fail_data <= '0;
      protocol_err    <= 1'b0;
    end else begin
      if (proto_hit) protocol_err <= 1'b1;
      if (compare) begin
        if (dut_result == pipe_exp[LATENCY-1]) begin
          if (pass_cnt != '1) pass_cnt <= pass_cnt + 1'b1;
        end else begin
          if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
          if (fail_cnt == '0) begin
            first_fail_idx  <= pipe_idx[LATENCY-1];
            first_fail_data <= dut_result;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_aes_kat_checker.sv
// tb/tb_aes_kat_checker.sv - directed self-checking bench for aes_kat_checker
module tb_aes_kat_checker;
  localparam logic [127:0] VA = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] VB = 128'hff0b844a0853bf7c6934ab4364148fb9;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         clear = 1'b0;
  logic         issue_valid = 1'b0;
  logic         end_test = 1'b0;
  logic [127:0] issue_expected = '0;
  logic [127:0] dut_result = '0;
  logic         busy, done, error, protocol_err;
  logic [15:0]  pass_cnt, fail_cnt, first_fail_idx;
  logic [127:0] first_fail_data;

  logic         s_issue_valid = 1'b0;
  logic         s_end_test = 1'b0;
  logic [127:0] s_issue_expected = '0;
  logic [127:0] s_dut_result = '0;
  logic         s_busy, s_done, s_error, s_protocol_err;
  logic [3:0]   s_pass_cnt, s_fail_cnt, s_first_fail_idx;
  logic [127:0] s_first_fail_data;

  logic [127:0] src = '0;
  logic [127:0] hist [0:2047];
  int           ecount = 0;
  int           n_err = 0;
  int           n_chk = 0;

  always #5 clk = ~clk;

  aes_kat_checker #(.DATA_W(128), .LATENCY(11), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .issue_valid(issue_valid), .issue_expected(issue_expected),
    .end_test(end_test), .dut_result(dut_result),
    .busy(busy), .done(done), .error(error), .protocol_err(protocol_err),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .first_fail_idx(first_fail_idx), .first_fail_data(first_fail_data)
  );

  aes_kat_checker #(.DATA_W(128), .LATENCY(11), .CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .clear(clear),
    .issue_valid(s_issue_valid), .issue_expected(s_issue_expected),
    .end_test(s_end_test), .dut_result(s_dut_result),
    .busy(s_busy), .done(s_done), .error(s_error), .protocol_err(s_protocol_err),
    .pass_cnt(s_pass_cnt), .fail_cnt(s_fail_cnt),
    .first_fail_idx(s_first_fail_idx), .first_fail_data(s_first_fail_data)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Core model: result for the vector sampled at edge e appears before edge e+11
  task automatic tick();
    hist[ecount % 2048] = src;
    @(posedge clk);
    #1;
    ecount++;
    dut_result = (ecount >= 11) ? hist[(ecount - 11) % 2048] : '0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic issue(input logic [127:0] e, input logic [127:0] r, input logic last);
    issue_valid    = 1'b1;
    issue_expected = e;
    src            = r;
    end_test       = last;
    tick();
    issue_valid = 1'b0;
    end_test    = 1'b0;
    src         = '0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  function automatic logic [127:0] vec(input int i);
    return (i % 2 == 0) ? VA : VB;
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_pass", pass_cnt, 0);
    idle(2);
    reset = 1'b0;
    idle(1);

    // Pass path: 12 back-to-back vectors, end_test with the last
    for (int i = 0; i < 12; i++) begin
      issue(vec(i), vec(i), i == 11);
      if (i == 0) check("pass_busy_run", busy, 1);
    end
    check("pass_first_compare", pass_cnt, 1);
    check("pass_drain_busy", busy, 1);
    idle(10);
    check("pass_pre_done", done, 0);
    check("pass_pre_cnt", pass_cnt, 11);
    idle(1);
    check("pass_done", done, 1);
    check("pass_busy_low", busy, 0);
    check("pass_cnt", pass_cnt, 12);
    check("pass_fail_cnt", fail_cnt, 0);
    check("pass_error", error, 0);
    do_clear();
    check("clear_pass", pass_cnt, 0);
    check("clear_done", done, 0);

    // Mismatch on the 3rd and 7th results
    for (int i = 0; i < 12; i++)
      issue(vec(i), vec(i) ^ ((i == 2 || i == 6) ? 128'h1 : 128'h0), i == 11);
    idle(11);
    check("mm_fail_cnt", fail_cnt, 2);
    check("mm_pass_cnt", pass_cnt, 10);
    check("mm_first_idx", first_fail_idx, 2);
    check("mm_first_data", first_fail_data, 128'h69c4e0d86a7b0430d8cdb78070b4c55b);
    check("mm_error", error, 1);
    check("mm_done", done, 1);
    do_clear();

    // Gaps, drain, then a protocol violation in DONE
    issue(VA, VA, 1'b0);
    idle(2);
    issue(VB, VB, 1'b0);
    idle(2);
    issue(VA, VA, 1'b0);
    end_test = 1'b1;
    tick();
    end_test = 1'b0;
    check("gap_drain_busy", busy, 1);
    idle(9);
    check("gap_pre_pass", pass_cnt, 2);
    check("gap_pre_done", done, 0);
    check("gap_pre_busy", busy, 1);
    idle(1);
    check("gap_done", done, 1);
    check("gap_pass", pass_cnt, 3);
    check("gap_proto_clean", protocol_err, 0);
    issue(VB, VB, 1'b0);
    check("gap_proto_err", protocol_err, 1);
    check("gap_error", error, 1);
    check("gap_done_hold", done, 1);
    idle(12);
    check("gap_pass_hold", pass_cnt, 3);
    check("gap_fail_hold", fail_cnt, 0);
    do_clear();

    // Async reset with four vectors in flight
    for (int i = 0; i < 4; i++) issue(vec(i), vec(i), 1'b0);
    idle(5);
    #2;
    reset = 1'b1;
    #1;
    check("ar_busy", busy, 0);
    check("ar_done", done, 0);
    check("ar_error", error, 0);
    idle(2);
    reset = 1'b0;
    idle(14);
    check("ar_no_late_pass", pass_cnt, 0);
    check("ar_no_late_fail", fail_cnt, 0);
    check("ar_first_data", first_fail_data, 0);
    check("ar_idle_busy", busy, 0);
    issue(VA, VA, 1'b0);
    issue(VB, VB, 1'b1);
    idle(11);
    check("ar_fresh_pass", pass_cnt, 2);
    check("ar_fresh_done", done, 1);

    // Saturation on the narrow-counter instance
    for (int i = 0; i < 20; i++) begin
      s_issue_valid    = 1'b1;
      s_issue_expected = VA;
      s_dut_result     = VB;
      s_end_test       = (i == 19);
      tick();
    end
    s_issue_valid = 1'b0;
    s_end_test    = 1'b0;
    idle(11);
    check("sat_fail_cnt", s_fail_cnt, 15);
    check("sat_pass_cnt", s_pass_cnt, 0);
    check("sat_first_idx", s_first_fail_idx, 0);
    check("sat_first_data", s_first_fail_data, VB);
    check("sat_done", s_done, 1);
    check("sat_error", s_error, 1);

    // end_test in IDLE with nothing issued
    do_clear();
    check("idle_pre_done", done, 0);
    end_test = 1'b1;
    tick();
    end_test = 1'b0;
    check("idle_end_done", done, 1);
    check("idle_end_busy", busy, 0);
    check("idle_end_pass", pass_cnt, 0);
    check("idle_end_fail", fail_cnt, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
